// File: rtl/pad_dir_sequencer.sv
`timescale 1ns/1ps
// Bidirectional pad sequencer: owns pad direction, synchronizes pad_i and inserts turnaround cycles.
// Optional majority-of-3 receive glitch filter enabled by defining PAD_DIR_SEQ_RX_FILTER_EN.
module pad_dir_sequencer #(
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_valid,
    input  logic tx_data,
    output logic tx_ready,
    output logic rx_valid,
    output logic rx_data,
    input  logic pad_i,
    output logic pad_o,
    output logic pad_oe
);

    // state    | meaning
    // RX       | pad released, inbound edges reported
    // TURN_OUT | dead cycles before driving the pad
    // TX       | outbound handshake, pad driven after first accepted bit
    // TURN_IN  | dead cycles before listening again
    localparam logic [1:0] ST_RX       = 2'd0;
    localparam logic [1:0] ST_TURN_OUT = 2'd1;
    localparam logic [1:0] ST_TX       = 2'd2;
    localparam logic [1:0] ST_TURN_IN  = 2'd3;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    logic [1:0]             r_state;
    logic [3:0]             r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_tx_ready;
    logic                   r_rx_valid;
    logic                   r_rx_data;
    logic                   r_pad_o;
    logic                   r_pad_oe;
    logic                   w_sync;
    logic                   w_level;

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PAD_DIR_SEQ_RX_FILTER_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b00;
        end else begin
            r_hist <= {r_hist[0], w_sync};
        end
    end

    // A level must be seen in two of the last three samples to count.
    assign w_level = (w_sync & r_hist[0]) | (w_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_level = w_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RX;
            r_cnt      <= 4'd0;
            r_last     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 1'b0;
            r_pad_o    <= 1'b0;
            r_pad_oe   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_RX: begin
                    // Outbound request wins; a coincident inbound edge is dropped.
                    if (tx_valid) begin
                        r_state <= ST_TURN_OUT;
                        r_cnt   <= TURN_LOAD;
                    end else if (w_level != r_last) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= w_level;
                        r_last     <= w_level;
                    end
                end
                ST_TURN_OUT: begin
                    if (!tx_valid) begin
                        r_state <= ST_TURN_IN;
                        r_cnt   <= TURN_LOAD;
                    end else if (r_cnt == 4'd0) begin
                        r_state    <= ST_TX;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_TX: begin
                    if (tx_valid) begin
                        if (r_tx_ready) begin
                            r_pad_o  <= tx_data;
                            r_pad_oe <= 1'b1;
                        end
                    end else begin
                        r_state    <= ST_TURN_IN;
                        r_cnt      <= TURN_LOAD;
                        r_pad_oe   <= 1'b0;
                        r_tx_ready <= 1'b0;
                    end
                end
                ST_TURN_IN: begin
                    // Re-arm edge detection at the current level so the turnaround is silent.
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RX;
                        r_last  <= w_level;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_RX;
                    r_pad_oe   <= 1'b0;
                    r_tx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign pad_o    = r_pad_o;
    assign pad_oe   = r_pad_oe;

endmodule

// File: tb/tb_pad_dir_sequencer.sv
`timescale 1ns/1ps
// Directed self-checking bench for pad_dir_sequencer at default parameters.
module tb_pad_dir_sequencer;

    logic clk;
    logic rst_n;
    logic tx_valid;
    logic tx_data;
    logic tx_ready;
    logic rx_valid;
    logic rx_data;
    logic pad_i;
    logic pad_o;
    logic pad_oe;

    int tests_run;
    int tests_failed;

    pad_dir_sequencer #(.TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .pad_i    (pad_i),
        .pad_o    (pad_o),
        .pad_oe   (pad_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Step pad_i and expect one rx_valid pulse three cycles later.
    task automatic rx_step(input logic val, input logic exp_data);
        pad_i = val;
        tick(); chk("rx_lat_c1", rx_valid, 1'b0);
        tick(); chk("rx_lat_c2", rx_valid, 1'b0);
        tick(); chk("rx_pulse", rx_valid, 1'b1); chk("rx_data", rx_data, exp_data);
        tick(); chk("rx_single", rx_valid, 1'b0); chk("rx_hold", rx_data, exp_data);
        tick(); chk("rx_quiet1", rx_valid, 1'b0);
        tick(); chk("rx_quiet2", rx_valid, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 1'b0;
        pad_i    = 1'b0;

        // Reset and idle
        #12;
        chk("rst_pad_oe", pad_oe, 1'b0);
        chk("rst_pad_o", pad_o, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_rx_valid", rx_valid, 1'b0);
            chk("idle_pad_oe", pad_oe, 1'b0);
            chk("idle_tx_ready", tx_ready, 1'b0);
        end

        // Turnaround latency and burst 1,0,1 with pad_i toggling during TX
        tx_valid = 1'b1; tx_data = 1'b1;
        chk("to_c0_ready", tx_ready, 1'b0); chk("to_c0_oe", pad_oe, 1'b0);
        tick(); chk("to_c1_ready", tx_ready, 1'b0); chk("to_c1_oe", pad_oe, 1'b0);
        tick(); chk("to_c2_ready", tx_ready, 1'b0); chk("to_c2_oe", pad_oe, 1'b0);
        tick(); chk("to_c3_ready", tx_ready, 1'b1); chk("to_c3_oe", pad_oe, 1'b0);
        tick(); chk("tx_c4_oe", pad_oe, 1'b1); chk("tx_c4_o", pad_o, 1'b1); chk("tx_c4_ready", tx_ready, 1'b1);
        tx_data = 1'b0; pad_i = 1'b1;
        tick(); chk("tx_c5_oe", pad_oe, 1'b1); chk("tx_c5_o", pad_o, 1'b0); chk("tx_c5_rxv", rx_valid, 1'b0);
        tx_data = 1'b1; pad_i = 1'b0;
        tick(); chk("tx_c6_oe", pad_oe, 1'b1); chk("tx_c6_o", pad_o, 1'b1); chk("tx_c6_rxv", rx_valid, 1'b0);
        tx_valid = 1'b0; pad_i = 1'b1;
        tick(); chk("drop_oe", pad_oe, 1'b0); chk("drop_ready", tx_ready, 1'b0); chk("drop_o_hold", pad_o, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_spurious_rxv", rx_valid, 1'b0);
            chk("no_spurious_oe", pad_oe, 1'b0);
        end
        chk("no_spurious_rxd", rx_data, 1'b0);

        // Receive steps
        rx_step(1'b0, 1'b0);
        rx_step(1'b1, 1'b1);
        rx_step(1'b0, 1'b0);

        // Re-request during TURN_IN, plus inbound edge coinciding with tx_valid in RX
        tx_valid = 1'b1; tx_data = 1'b0;
        tick(); tick();
        tick(); chk("b2_c3_ready", tx_ready, 1'b1);
        tick(); chk("b2_c4_oe", pad_oe, 1'b1); chk("b2_c4_o", pad_o, 1'b0);
        tx_valid = 1'b0;
        tick(); chk("b2_c5_oe", pad_oe, 1'b0); chk("b2_c5_ready", tx_ready, 1'b0); chk("b2_c5_rxv", rx_valid, 1'b0);
        tx_valid = 1'b1; tx_data = 1'b1; pad_i = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            tick();
            chk("b2_wait_ready", tx_ready, 1'b0);
            chk("b2_wait_oe", pad_oe, 1'b0);
            chk("b2_coincide_rxv", rx_valid, 1'b0);
        end
        tick(); chk("b2_c10_ready", tx_ready, 1'b1); chk("b2_c10_rxv", rx_valid, 1'b0);
        tick(); chk("b2_c11_oe", pad_oe, 1'b1); chk("b2_c11_o", pad_o, 1'b1);

        // Asynchronous reset while driving
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", pad_oe, 1'b0);
        chk("arst_ready", tx_ready, 1'b0);
        chk("arst_o", pad_o, 1'b0);
        chk("arst_rxv", rx_valid, 1'b0);
        #2 rst_n = 1'b1; tx_valid = 1'b0;
        tick(); chk("post_oe", pad_oe, 1'b0); chk("post_ready", tx_ready, 1'b0); chk("post_o", pad_o, 1'b0); chk("post_rxv", rx_valid, 1'b0);
        tick(); chk("post_rxv2", rx_valid, 1'b0);
        tick(); chk("post_rx_pulse", rx_valid, 1'b1); chk("post_rx_data", rx_data, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
